// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   WIDTH-bit synchronous up/down counter with a programmable terminal value
//   (MAX), parallel load, and wrap or saturate behaviour at the range ends.
//   Drives DIGITS active-low seven-segment hex displays straight from the count.
//
// Ports
//   clk        in   rising-edge clock
//   clear      in   asynchronous active-high reset (count=0, wrap=0)
//   enable     in   count enable
//   up_down    in   1 = count up, 0 = count down
//   load       in   synchronous parallel load strobe (beats enable)
//   load_value in   value to load, clamped to MAX
//   count      out  registered count, range 0..MAX
//   tc         out  combinational terminal count, cascade enable for a next stage
//   wrap       out  registered one-cycle pulse after each wrap event
//   hex        out  segments, digit k at hex[7k+6:7k], bit 0 = a .. bit 6 = g
module mod_updown_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 255,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned DIGITS   = 2
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   hex
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
    localparam int unsigned      HexW   = 4 * DIGITS;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero, above_max;

    assign at_max    = (count_q == MaxVal);
    assign at_zero   = (count_q == '0);
    assign above_max = (count_q > MaxVal);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_value > MaxVal) ? MaxVal : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (above_max) begin
                    // Recover from an illegal state silently: no wrap pulse.
                    count_d = '0;
                end else if (at_max) begin
                    if (!SATURATE) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    if (!SATURATE) begin
                        count_d = MaxVal;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = enable & ~load & ((up_down & at_max) | (~up_down & at_zero));

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Zero-extend so a partial top nibble decodes with its high bits as 0.
    logic [HexW-1:0] count_ext;
    assign count_ext = HexW'(count_q);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign hex[7*k +: 7] = seg_decode(count_ext[4*k +: 4]);
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       clear, enable, up_down, load;
    logic [7:0] load_value;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] count;
        logic       wrap;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0]  def_count, m9_count, sat_count, m99_count;
    logic        def_tc, m9_tc, sat_tc, m99_tc, m0_tc;
    logic        def_wrap, m9_wrap, sat_wrap, m99_wrap, m0_wrap;
    logic [13:0] def_hex, m9_hex, sat_hex, m99_hex;
    logic [3:0]  m0_count;
    logic [6:0]  m0_hex;

    mod_updown_counter u_def (
        .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .count(def_count), .tc(def_tc), .wrap(def_wrap), .hex(def_hex)
    );
    mod_updown_counter #(.MAX(9)) u_m9 (
        .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .count(m9_count), .tc(m9_tc), .wrap(m9_wrap), .hex(m9_hex)
    );
    mod_updown_counter #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .count(sat_count), .tc(sat_tc), .wrap(sat_wrap), .hex(sat_hex)
    );
    mod_updown_counter #(.MAX(99)) u_m99 (
        .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .count(m99_count), .tc(m99_tc), .wrap(m99_wrap), .hex(m99_hex)
    );
    mod_updown_counter #(.WIDTH(4), .MAX(0), .DIGITS(1)) u_m0 (
        .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value[3:0]), .count(m0_count), .tc(m0_tc), .wrap(m0_wrap),
        .hex(m0_hex)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load       = 1'b0;
        enable     = 1'b0;
        up_down    = 1'b1;
        load_value = 8'h00;
    endtask

    task automatic test_reset();
        exp_t e;
        clear = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (def_count !== 8'h00) begin
            failures++;
            $display("FAIL reset_count got=%h exp=00", def_count);
        end
        checks++;
        if (def_wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_wrap got=%b exp=0", def_wrap);
        end
        checks++;
        if (def_hex !== 14'h2040) begin
            failures++;
            $display("FAIL reset_hex got=%h exp=2040", def_hex);
        end
        // Count to 0x5A, then clear for 3 cycles with enable still high.
        clear      = 1'b0;
        load       = 1'b1;
        load_value = 8'h59;
        tick();
        load    = 1'b0;
        enable  = 1'b1;
        sb_q.push_back('{count: 8'h5A, wrap: 1'b0});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (def_count !== e.count || def_wrap !== e.wrap) begin
            failures++;
            $display("FAIL count_5a got=%h/%b exp=%h/%b", def_count, def_wrap, e.count, e.wrap);
        end
        checks++;
        if (def_hex !== 14'h0908) begin
            failures++;
            $display("FAIL hex_5a got=%h exp=0908", def_hex);
        end
        clear = 1'b1;
        #1;
        checks++;
        if (def_count !== 8'h00) begin
            failures++;
            $display("FAIL clear_immediate got=%h exp=00", def_count);
        end
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{count: 8'h00, wrap: 1'b0});
            tick();
            e = sb_q.pop_front();
            checks++;
            if (def_count !== e.count || def_wrap !== e.wrap) begin
                failures++;
                $display("FAIL clear_hold[%0d] got=%h/%b exp=%h/%b", i, def_count, def_wrap,
                         e.count, e.wrap);
            end
        end
        clear  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{count: 8'h00, wrap: 1'b0});
            tick();
            e = sb_q.pop_front();
            checks++;
            if (def_count !== e.count || def_wrap !== e.wrap || def_hex !== 14'h2040) begin
                failures++;
                $display("FAIL release_hold[%0d] got=%h/%b/%h exp=%h/%b/2040", i, def_count,
                         def_wrap, def_hex, e.count, e.wrap);
            end
        end
    endtask

    task automatic test_up_wrap();
        exp_t       e;
        logic [7:0] exp_c[3] = '{8'd9, 8'd0, 8'd1};
        logic       exp_w[3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_t_[3] = '{1'b0, 1'b1, 1'b0};
        idle_inputs();
        load       = 1'b1;
        load_value = 8'd8;
        sb_q.push_back('{count: 8'd8, wrap: 1'b0});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (m9_count !== e.count || m9_wrap !== e.wrap) begin
            failures++;
            $display("FAIL up_load8 got=%0d/%b exp=%0d/%b", m9_count, m9_wrap, e.count, e.wrap);
        end
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (m9_tc !== exp_t_[i]) begin
                failures++;
                $display("FAIL up_tc[%0d] got=%b exp=%b", i, m9_tc, exp_t_[i]);
            end
            sb_q.push_back('{count: exp_c[i], wrap: exp_w[i]});
            tick();
            e = sb_q.pop_front();
            checks++;
            if (m9_count !== e.count || m9_wrap !== e.wrap) begin
                failures++;
                $display("FAIL up_wrap[%0d] got=%0d/%b exp=%0d/%b", i, m9_count, m9_wrap,
                         e.count, e.wrap);
            end
        end
    endtask

    task automatic test_down_wrap();
        exp_t       e;
        logic [7:0] exp_c[2] = '{8'd9, 8'd8};
        logic       exp_w[2] = '{1'b1, 1'b0};
        logic       exp_t_[2] = '{1'b1, 1'b0};
        idle_inputs();
        load       = 1'b1;
        load_value = 8'd0;
        sb_q.push_back('{count: 8'd0, wrap: 1'b0});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (m9_count !== e.count || m9_wrap !== e.wrap) begin
            failures++;
            $display("FAIL down_load0 got=%0d/%b exp=%0d/%b", m9_count, m9_wrap, e.count, e.wrap);
        end
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (m9_tc !== exp_t_[i]) begin
                failures++;
                $display("FAIL down_tc[%0d] got=%b exp=%b", i, m9_tc, exp_t_[i]);
            end
            sb_q.push_back('{count: exp_c[i], wrap: exp_w[i]});
            tick();
            e = sb_q.pop_front();
            checks++;
            if (m9_count !== e.count || m9_wrap !== e.wrap) begin
                failures++;
                $display("FAIL down_wrap[%0d] got=%0d/%b exp=%0d/%b", i, m9_count, m9_wrap,
                         e.count, e.wrap);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        logic exp_t_[3] = '{1'b0, 1'b1, 1'b1};
        for (int phase = 0; phase < 2; phase++) begin
            idle_inputs();
            load       = 1'b1;
            load_value = (phase == 0) ? 8'd254 : 8'd1;
            sb_q.push_back('{count: load_value, wrap: 1'b0});
            tick();
            e = sb_q.pop_front();
            checks++;
            if (sat_count !== e.count || sat_wrap !== e.wrap) begin
                failures++;
                $display("FAIL sat_load[%0d] got=%0d/%b exp=%0d/%b", phase, sat_count, sat_wrap,
                         e.count, e.wrap);
            end
            load    = 1'b0;
            enable  = 1'b1;
            up_down = (phase == 0);
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (sat_tc !== exp_t_[i]) begin
                    failures++;
                    $display("FAIL sat_tc[%0d][%0d] got=%b exp=%b", phase, i, sat_tc, exp_t_[i]);
                end
                sb_q.push_back('{count: (phase == 0) ? 8'd255 : 8'd0, wrap: 1'b0});
                tick();
                e = sb_q.pop_front();
                checks++;
                if (sat_count !== e.count || sat_wrap !== e.wrap) begin
                    failures++;
                    $display("FAIL sat_count[%0d][%0d] got=%0d/%b exp=%0d/%b", phase, i,
                             sat_count, sat_wrap, e.count, e.wrap);
                end
            end
        end
    endtask

    task automatic test_load_clamp();
        exp_t e;
        exp_t exp_s[3] = '{'{count: 8'd99, wrap: 1'b0}, '{count: 8'd99, wrap: 1'b0},
                           '{count: 8'd0, wrap: 1'b1}};
        logic exp_t_[3] = '{1'b0, 1'b0, 1'b1};
        idle_inputs();
        enable     = 1'b1;
        up_down    = 1'b1;
        load_value = 8'd150;
        for (int i = 0; i < 3; i++) begin
            // Two load cycles (second one at the boundary), then plain counting.
            load = (i < 2);
            #1;
            checks++;
            if (m99_tc !== exp_t_[i]) begin
                failures++;
                $display("FAIL clamp_tc[%0d] got=%b exp=%b", i, m99_tc, exp_t_[i]);
            end
            sb_q.push_back(exp_s[i]);
            tick();
            e = sb_q.pop_front();
            checks++;
            if (m99_count !== e.count || m99_wrap !== e.wrap) begin
                failures++;
                $display("FAIL clamp[%0d] got=%0d/%b exp=%0d/%b", i, m99_count, m99_wrap,
                         e.count, e.wrap);
            end
        end
    endtask

    task automatic test_async_clear();
        exp_t e;
        idle_inputs();
        load       = 1'b1;
        load_value = 8'h3C;
        sb_q.push_back('{count: 8'h3C, wrap: 1'b0});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (def_count !== e.count || def_wrap !== e.wrap) begin
            failures++;
            $display("FAIL aclr_load got=%h/%b exp=%h/%b", def_count, def_wrap, e.count, e.wrap);
        end
        load = 1'b0;
        #3;
        clear = 1'b1;
        #1;
        checks++;
        if (def_count !== 8'h00 || def_wrap !== 1'b0) begin
            failures++;
            $display("FAIL aclr_mid got=%h/%b exp=00/0", def_count, def_wrap);
        end
        #1;
        clear   = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        sb_q.push_back('{count: 8'h01, wrap: 1'b0});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (def_count !== e.count || def_wrap !== e.wrap) begin
            failures++;
            $display("FAIL aclr_restart got=%h/%b exp=%h/%b", def_count, def_wrap, e.count,
                     e.wrap);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        idle_inputs();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_down = (i < 2);
            #1;
            checks++;
            if (m0_tc !== 1'b1) begin
                failures++;
                $display("FAIL max0_tc[%0d] got=%b exp=1", i, m0_tc);
            end
            sb_q.push_back('{count: 8'h00, wrap: 1'b1});
            tick();
            e = sb_q.pop_front();
            checks++;
            if ({4'h0, m0_count} !== e.count || m0_wrap !== e.wrap || m0_hex !== 7'b1000000) begin
                failures++;
                $display("FAIL max0_wrap[%0d] got=%h/%b/%b exp=%h/%b/1000000", i, m0_count,
                         m0_wrap, m0_hex, e.count, e.wrap);
            end
        end
    endtask

    // Random traffic on the MAX=9 counter against a reference model.
    task automatic test_random();
        exp_t       e;
        logic [7:0] mc;
        logic       mw, mt;
        idle_inputs();
        load       = 1'b1;
        load_value = 8'd0;
        tick();
        mc = 8'd0;
        for (int i = 0; i < 60; i++) begin
            load       = ($urandom_range(0, 7) == 0);
            enable     = ($urandom_range(0, 3) != 0);
            up_down    = $urandom_range(0, 1) == 1;
            load_value = 8'($urandom_range(0, 255));
            mt = enable && !load && ((up_down && mc == 8'd9) || (!up_down && mc == 8'd0));
            mw = 1'b0;
            if (load) begin
                mc = (load_value > 8'd9) ? 8'd9 : load_value;
            end else if (enable && up_down) begin
                if (mc == 8'd9) begin
                    mc = 8'd0;
                    mw = 1'b1;
                end else begin
                    mc = mc + 8'd1;
                end
            end else if (enable) begin
                if (mc == 8'd0) begin
                    mc = 8'd9;
                    mw = 1'b1;
                end else begin
                    mc = mc - 8'd1;
                end
            end
            #1;
            checks++;
            if (m9_tc !== mt) begin
                failures++;
                $display("FAIL rand_tc[%0d] got=%b exp=%b", i, m9_tc, mt);
            end
            sb_q.push_back('{count: mc, wrap: mw});
            tick();
            e = sb_q.pop_front();
            checks++;
            if (m9_count !== e.count || m9_wrap !== e.wrap) begin
                failures++;
                $display("FAIL rand[%0d] got=%0d/%b exp=%0d/%b", i, m9_count, m9_wrap, e.count,
                         e.wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_clamp();
        test_async_clear();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
